funnel_2to1: RTL and testbench
==============================

Name: funnel_2to1

Overview:
- Merges two half-rate 16-bit lanes into a single full-rate 200 MHz word stream for the downstream DSP48E1 path.
- Each accepted input pair is emitted as lane-0 word then lane-1 word, on consecutive output handshakes.
- A small pair FIFO absorbs output backpressure.
- Sits at the serialising end of the data-burst TDM path, opposite the 1-to-2 funnel.

Parameters:
- WIDTH, 16, bit width of each lane word and of dout.
- DEPTH, 2, pair FIFO depth in pairs; power of two, minimum 2.

Ports:
- clk  input  1  200 MHz clock, single clock domain.
- rst_n  input  1  asynchronous active-low reset.
- din0  input  WIDTH  lane-0 word of the pair; emitted first.
- din1  input  WIDTH  lane-1 word of the pair; emitted second.
- in_valid  input  1  pair on din0/din1 is valid.
- in_ready  output  1  block can accept a pair this cycle.
- dout  output  WIDTH  serialised output word.
- dout_lane  output  1  source lane of dout: 0 = din0, 1 = din1.
- dout_valid  output  1  dout holds a valid word.
- dout_ready  input  1  downstream accepts dout this cycle.

Behaviour:
- Reset (async assert, sync release): FIFO empty, state EMPTY, dout=0, dout_lane=0, dout_valid=0.
- in_ready=1 out of reset.
- All buffered data is discarded on reset at any point, including mid-pair; the first word after release is lane 0 of the next accepted pair.
- Push: in_valid && in_ready at a rising edge writes {din0,din1} to the FIFO tail.
- in_ready = !fifo_full, driven from registered count only; no combinational path from dout_ready.
- Output FSM states: EMPTY, LANE0, LANE1. dout_valid=1 in LANE0 and LANE1.
- Load condition: state==EMPTY, or (state==LANE1 && dout_ready).
- Load with FIFO non-empty: pop head; dout<=head.d0, dout_lane<=0, hold_d1<=head.d1, go to LANE0.
- Load with FIFO empty: go to EMPTY; dout_valid=0 and dout keeps its last value.
- LANE0 && dout_ready: dout<=hold_d1, dout_lane<=1, go to LANE1.
- LANE0 or LANE1 with !dout_ready: dout, dout_lane and state hold. Stability is required while dout_valid && !dout_ready.
- Latency: pair accepted at edge k into an empty block gives dout=din0 after edge k+1 and dout=din1 after edge k+2 (dout_ready=1).
- Throughput: one pair per 2 cycles sustained, gapless output stream.
- Pushing faster than that fills the FIFO, and in_ready deasserts.
- Capacity: DEPTH pairs in the FIFO plus one pair in the output/hold stage.
- FIFO pointers are log2(DEPTH) bits with an extra wrap bit; full = MSBs differ and lower bits are equal.
- Push and pop in the same cycle are allowed when not full.
- Push and pop in the same cycle when full: pop happens, push is refused (in_ready was 0).
- Count update: simultaneous push and pop leaves count unchanged.

Optional Feature:
- Macro FUNNEL_2TO1_CNT_EN.
- Defined: adds output port word_cnt (32 bits). It is reset to 0 and increments by 1 on every dout_valid && dout_ready edge, wrapping 0xFFFFFFFF->0.
- Not defined: no port, no counter logic, behaviour otherwise identical.

Decomposition:
- Package funnel_pkg holds:
  - localparam FUNNEL_WIDTH=16.
  - typedef struct packed {logic [WIDTH-1:0] d0, d1;} funnel_pair_t.
  - typedef enum logic [1:0] {EMPTY, LANE0, LANE1} funnel_state_t.
- Sub-module funnel_pair_fifo: DEPTH-entry synchronous FIFO of funnel_pair_t with push/pop/full/empty outputs.
- funnel_2to1 contains the output FSM and the hold register.

Test Plan:
- Reset: rst_n=0 asynchronously mid-burst -> dout_valid=0, dout=0, in_ready=1 immediately, with no clock edge required.
- Single pair: {0x1111,0x2222} accepted at edge k, dout_ready=1 -> after k+1 dout=0x1111/lane0; after k+2 dout=0x2222/lane1; after k+3 dout_valid=0.
- Streaming: pairs {0xA000+i, 0xB000+i} for i=0..7, one every 2 cycles, dout_ready=1 -> 16 consecutive valid words A0,B0,A1,B1,...,B7 with no bubbles; in_ready never 0.
- Backpressure fill: dout_ready=0, in_valid=1 continuously, DEPTH=2 -> exactly 3 pairs accepted; in_ready=0 from the 4th cycle; dout=0x first pair d0 held stable.
- Drain and release: after the fill case, dout_ready=1 -> 6 words in order; in_ready returns to 1 the cycle after the first pop; no word lost or duplicated.
- Random valid/ready (10k cycles, scoreboard) -> output order equals d0,d1 per accepted pair. With FUNNEL_2TO1_CNT_EN, word_cnt equals the handshake count; the counter preloaded near wrap shows 0xFFFFFFFF->0.

Source files
------------

// File: rtl/funnel_pkg.sv
// funnel_pkg: shared types and constants for the 2-to-1 lane funnel.
// The optional word counter on funnel_2to1 is enabled by FUNNEL_2TO1_CNT_EN.
package funnel_pkg;

  // Lane word width used by the pair type.
  localparam int FUNNEL_WIDTH = 16;

  // Default pair FIFO depth in pairs (power of two, at least 2).
  localparam int FUNNEL_DEPTH = 2;

  // One accepted input pair; d0 is emitted first, d1 second.
  typedef struct packed {
    logic [FUNNEL_WIDTH-1:0] d0;
    logic [FUNNEL_WIDTH-1:0] d1;
  } funnel_pair_t;

  // Output stage: nothing presented, presenting d0, presenting d1.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LANE0 = 2'd1,
    LANE1 = 2'd2
  } funnel_state_t;

  // Pointer index width for a FIFO of the given depth (wrap bit not included).
  function automatic int funnel_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/funnel_pair_fifo.sv
// funnel_pair_fifo: small synchronous FIFO of funnel_pair_t.
// Pointers carry one extra wrap bit so full and empty are told apart
// without a separate occupancy counter; simultaneous push and pop leave
// the occupancy unchanged. Push is ignored when full, pop when empty.
module funnel_pair_fifo
  import funnel_pkg::*;
#(
  parameter int DEPTH = FUNNEL_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  funnel_pair_t wr_pair,
  input  logic         pop,
  output funnel_pair_t head,
  output logic         full,
  output logic         empty
);

  localparam int AW = funnel_ptr_w(DEPTH);

  logic [AW:0]  wr_ptr_reg;
  logic [AW:0]  rd_ptr_reg;
  funnel_pair_t mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Advance write/read pointers on accepted push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  // Pair storage; contents need no reset because the pointers gate access.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= wr_pair;
  end

  // Head is visible immediately so the output stage can load it on pop.
  assign head  = mem[rd_ptr_reg[AW-1:0]];
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

endmodule

// File: rtl/funnel_2to1.sv
// funnel_2to1: serialises lane pairs {din0, din1} into a single word stream,
// lane 0 first. A pair FIFO absorbs output backpressure; the output stage
// holds one more pair (dout plus hold_d1).
// Define FUNNEL_2TO1_CNT_EN to add the 32-bit word_cnt handshake counter.
// WIDTH must match FUNNEL_WIDTH since the pair type is fixed in funnel_pkg.
module funnel_2to1
  import funnel_pkg::*;
#(
  parameter int WIDTH = FUNNEL_WIDTH,
  parameter int DEPTH = FUNNEL_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_lane,
  output logic             dout_valid,
  input  logic             dout_ready
`ifdef FUNNEL_2TO1_CNT_EN
  ,
  output logic [31:0]      word_cnt
`endif
);

  funnel_state_t    state_reg;
  funnel_state_t    state_next;
  logic             load;
  logic             load_head;
  logic             advance;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  funnel_pair_t     push_pair;
  funnel_pair_t     fifo_head;
  logic [WIDTH-1:0] dout_reg;
  logic             lane_reg;
  logic [WIDTH-1:0] hold_d1_reg;

  // in_ready depends only on registered FIFO pointers, never on dout_ready.
  assign in_ready    = !fifo_full;
  assign fifo_push   = in_valid && in_ready;
  assign push_pair.d0 = din0;
  assign push_pair.d1 = din1;

  funnel_pair_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (fifo_push),
    .wr_pair (push_pair),
    .pop     (fifo_pop),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Output FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= EMPTY;
    else        state_reg <= state_next;
  end

  // A new pair may enter the output stage when idle or when lane 1 leaves.
  assign load = (state_reg == EMPTY) || ((state_reg == LANE1) && dout_ready);

  // Next-state logic: load a pair, step lane 0 -> lane 1, or hold.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY: begin
        state_next = fifo_empty ? EMPTY : LANE0;
      end
      LANE0: begin
        if (dout_ready) state_next = LANE1;
      end
      LANE1: begin
        if (dout_ready) state_next = fifo_empty ? EMPTY : LANE0;
      end
      default: state_next = EMPTY;
    endcase
  end

  // FSM outputs: valid flag, FIFO pop and datapath load/advance strobes.
  always_comb begin
    dout_valid = 1'b0;
    load_head  = 1'b0;
    advance    = 1'b0;
    case (state_reg)
      LANE0: begin
        dout_valid = 1'b1;
        advance    = dout_ready;
      end
      LANE1: begin
        dout_valid = 1'b1;
      end
      default: begin
        dout_valid = 1'b0;
      end
    endcase
    load_head = load && !fifo_empty;
  end

  assign fifo_pop = load_head;

  // Output datapath: present d0 and park d1 on load, then swap in d1.
  // When nothing is loaded dout keeps its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_reg    <= '0;
      lane_reg    <= 1'b0;
      hold_d1_reg <= '0;
    end else if (load_head) begin
      dout_reg    <= fifo_head.d0;
      lane_reg    <= 1'b0;
      hold_d1_reg <= fifo_head.d1;
    end else if (advance) begin
      dout_reg    <= hold_d1_reg;
      lane_reg    <= 1'b1;
    end
  end

  assign dout      = dout_reg;
  assign dout_lane = lane_reg;

`ifdef FUNNEL_2TO1_CNT_EN
  logic [31:0] word_cnt_reg;

  // Count output handshakes; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         word_cnt_reg <= '0;
    else if (dout_valid && dout_ready)  word_cnt_reg <= word_cnt_reg + 32'd1;
  end

  assign word_cnt = word_cnt_reg;
`endif

endmodule

// File: tb/tb_funnel_2to1.sv
// tb_funnel_2to1: directed and randomized checks of funnel_2to1 against a
// word-queue reference model (each accepted pair expands to d0 then d1).
module tb_funnel_2to1;
  import funnel_pkg::*;

  localparam int W = FUNNEL_WIDTH;
  localparam int D = FUNNEL_DEPTH;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [W-1:0] din0 = '0;
  logic [W-1:0] din1 = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] dout;
  logic         dout_lane;
  logic         dout_valid;
  logic         dout_ready = 1'b0;
`ifdef FUNNEL_2TO1_CNT_EN
  logic [31:0]  word_cnt;
`endif

  funnel_2to1 #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din0       (din0),
    .din1       (din1),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dout       (dout),
    .dout_lane  (dout_lane),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
`ifdef FUNNEL_2TO1_CNT_EN
    ,
    .word_cnt   (word_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: expected words in output order, {lane, data}.
  logic [W:0]   exp_q[$];
  logic [31:0]  hs_total = '0;
  int           cyc = 0;
  int           hs_phase = 0;
  int           acc_phase = 0;
  int           first_hs = -1;
  int           last_hs = -1;
  bit           verbose = 1'b1;

  // Last sampled DUT outputs.
  logic         s_valid, s_ready, s_lane;
  logic [W-1:0] s_dout;
  // Previous sample, for the hold-while-stalled rule.
  bit           p_have = 1'b0;
  logic         p_valid, p_ready, p_lane;
  logic [W-1:0] p_dout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic phase_start();
    hs_phase  = 0;
    acc_phase = 0;
    first_hs  = -1;
    last_hs   = -1;
  endtask

  // One clock: drive after the edge, sample at the falling edge, and
  // account for the handshakes that the next rising edge will perform.
  task automatic cycle(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic dr);
    logic [W:0] e;
    @(posedge clk);
    #1;
    in_valid   = iv;
    din0       = a;
    din1       = b;
    dout_ready = dr;
    @(negedge clk);
    cyc++;
    s_valid = dout_valid;
    s_ready = in_ready;
    s_lane  = dout_lane;
    s_dout  = dout;

    if (p_have && p_valid && !p_ready) begin
      chk("stall_valid", dout_valid, 1);
      chk("stall_dout", dout, p_dout);
      chk("stall_lane", dout_lane, p_lane);
    end

    // Full FIFO implies DEPTH pairs buffered; never more than DEPTH+1 pairs.
    if (!in_ready) chk("full_occupancy", exp_q.size() >= 2*D, 1);
    chk("max_occupancy", exp_q.size() <= 2*(D+1), 1);

`ifdef FUNNEL_2TO1_CNT_EN
    chk("word_cnt", word_cnt, hs_total);
`endif

    if (dout_valid && dout_ready) begin
      chk("sb_has_word", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_data", dout, e[W-1:0]);
        chk("sb_lane", dout_lane, e[W]);
      end
      hs_phase++;
      hs_total = hs_total + 32'd1;
      if (first_hs < 0) first_hs = cyc;
      last_hs = cyc;
      if (verbose) $display("xfer cycle=%0d lane=%0d data=%h", cyc, dout_lane, dout);
    end

    if (in_valid && in_ready) begin
      exp_q.push_back({1'b0, a});
      exp_q.push_back({1'b1, b});
      acc_phase++;
    end

    p_have  = 1'b1;
    p_valid = dout_valid;
    p_ready = dout_ready;
    p_lane  = dout_lane;
    p_dout  = dout;
  endtask

  // Assert reset away from any clock edge and check outputs at once.
  task automatic async_reset();
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_valid", dout_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_lane", dout_lane, 0);
    chk("rst_in_ready", in_ready, 1);
`ifdef FUNNEL_2TO1_CNT_EN
    chk("rst_word_cnt", word_cnt, 0);
`endif
    exp_q.delete();
    hs_total = '0;
    p_have   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Power-on reset.
    async_reset();

    // Single pair latency.
    phase_start();
    cycle(1'b1, 16'h1111, 16'h2222, 1'b1);
    chk("single_accept", acc_phase, 1);
    cycle(1'b0, 16'h0, 16'h0, 1'b1);
    chk("single_k0_valid", s_valid, 0);
    cycle(1'b0, 16'h0, 16'h0, 1'b1);
    chk("single_k1_valid", s_valid, 1);
    chk("single_k1_dout", s_dout, 16'h1111);
    chk("single_k1_lane", s_lane, 0);
    cycle(1'b0, 16'h0, 16'h0, 1'b1);
    chk("single_k2_valid", s_valid, 1);
    chk("single_k2_dout", s_dout, 16'h2222);
    chk("single_k2_lane", s_lane, 1);
    cycle(1'b0, 16'h0, 16'h0, 1'b1);
    chk("single_k3_valid", s_valid, 0);

    // Streaming at one pair per two cycles: gapless output.
    phase_start();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, W'(16'hA000 + i), W'(16'hB000 + i), 1'b1);
      chk("stream_in_ready", s_ready, 1);
      cycle(1'b0, 16'h0, 16'h0, 1'b1);
      chk("stream_in_ready", s_ready, 1);
    end
    repeat (4) cycle(1'b0, 16'h0, 16'h0, 1'b1);
    chk("stream_words", hs_phase, 16);
    chk("stream_gapless", last_hs - first_hs, 15);
    chk("stream_drained", exp_q.size(), 0);

    // Backpressure fill: DEPTH pairs plus one in the output stage.
    phase_start();
    for (int n = 0; n < 6; n++) begin
      cycle(1'b1, W'(16'hC000 + n), W'(16'hD000 + n), 1'b0);
      chk("fill_in_ready", s_ready, (n < 3) ? 1 : 0);
      if (n >= 2) begin
        chk("fill_valid", s_valid, 1);
        chk("fill_dout", s_dout, 16'hC000);
      end
    end
    chk("fill_accepted", acc_phase, 3);

    // Drain: six words in order, in_ready back once the FIFO pops.
    phase_start();
    for (int n = 0; n < 10; n++) begin
      cycle(1'b0, 16'h0, 16'h0, 1'b1);
      if (n == 1) chk("drain_in_ready_before", s_ready, 0);
      if (n == 2) chk("drain_in_ready_after", s_ready, 1);
    end
    chk("drain_words", hs_phase, 6);
    chk("drain_empty", exp_q.size(), 0);

    // Reset mid-burst discards everything; next word is lane 0 of a new pair.
    phase_start();
    for (int i = 0; i < 3; i++) cycle(1'b1, W'(16'hE000 + i), W'(16'hE100 + i), 1'b0);
    async_reset();
    phase_start();
    cycle(1'b1, 16'hF000, 16'hF001, 1'b1);
    cycle(1'b0, 16'h0, 16'h0, 1'b1);
    cycle(1'b0, 16'h0, 16'h0, 1'b1);
    chk("post_rst_dout", s_dout, 16'hF000);
    chk("post_rst_lane", s_lane, 0);
    repeat (3) cycle(1'b0, 16'h0, 16'h0, 1'b1);
    chk("post_rst_words", hs_phase, 2);

    // Randomized valid/ready against the scoreboard.
    verbose = 1'b0;
    phase_start();
    for (int i = 0; i < 10000; i++) begin
      int pv;
      int pr;
      pv = (i / 1000) % 3;
      pr = (i / 700) % 3;
      cycle(($urandom_range(0, 3) < 3 - pv) ? 1'b1 : 1'b0,
            W'($urandom), W'($urandom),
            ($urandom_range(0, 3) < 3 - pr) ? 1'b1 : 1'b0);
    end
    repeat (20) cycle(1'b0, 16'h0, 16'h0, 1'b1);
    chk("random_drained", exp_q.size(), 0);
    chk("random_balance", hs_phase, 2 * acc_phase);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
